// File: rtl/noc_input_port_vc_if.sv
// Link and switch-side signals of the NoC input port.
// The DUT uses the slave modport; the upstream link/switch model uses master.
interface noc_input_port_vc_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned FLIT_W   = 32
);
    localparam int unsigned VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                in_valid;
    logic [VC_W-1:0]     in_vc;
    logic [FLIT_W-1:0]   in_flit;
    logic [CHANNELS-1:0] credit_valid;
    logic                out_valid;
    logic                out_ready;
    logic [FLIT_W-1:0]   out_flit;
    logic [VC_W-1:0]     out_vc;
    logic [4:0]          out_port;

    modport master (
        output in_valid, in_vc, in_flit, out_ready,
        input  credit_valid, out_valid, out_flit, out_vc, out_port
    );

    modport slave (
        input  in_valid, in_vc, in_flit, out_ready,
        output credit_valid, out_valid, out_flit, out_vc, out_port
    );
endinterface

// File: rtl/noc_input_port_vc.sv
// NoC input port: per-VC FIFOs, XY routing, wormhole lock and round-robin switch request.
// Drop statistics counter is built only when NOC_INPUT_PORT_STATS_EN is defined.
module noc_input_port_vc #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned FLIT_W        = 32,
    parameter int unsigned ID_X_W        = 4,
    parameter int unsigned ID_Y_W        = 4,
    parameter logic [4:0]  ACTIVATE_PORT = 5'b11111
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic [ID_X_W-1:0]     id_x,
    input  logic [ID_Y_W-1:0]     id_y,
    noc_input_port_vc_if.slave    link,
    output logic                  overflow_err,
    output logic [15:0]           drop_cnt
);
    localparam int unsigned VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = AW + 1;

    typedef enum logic [1:0] {StIdle, StRoute, StDrop} vc_state_e;

    logic [FLIT_W-1:0]   mem_q    [CHANNELS][DEPTH];
    logic [PW-1:0]       wr_ptr_q [CHANNELS];
    logic [PW-1:0]       wr_ptr_d [CHANNELS];
    logic [PW-1:0]       rd_ptr_q [CHANNELS];
    logic [PW-1:0]       rd_ptr_d [CHANNELS];
    vc_state_e           state_q  [CHANNELS];
    vc_state_e           state_d  [CHANNELS];
    logic [4:0]          lock_q   [CHANNELS];
    logic [4:0]          lock_d   [CHANNELS];
    logic [FLIT_W-1:0]   head     [CHANNELS];
    logic [4:0]          route    [CHANNELS];
    logic [4:0]          req_port [CHANNELS];

    logic [CHANNELS-1:0] empty, full, is_head, is_tail, req, drop_pop;
    logic [CHANNELS-1:0] wr_en, push, pop, drop_done, credit_q;
    logic [VC_W-1:0]     rr_q, rr_d, arb_vc, cand_vc, sel_vc, hold_vc_q;
    logic                hold_q, arb_found, hs, overflow_q, overflow_d;
    int unsigned         idx;

    function automatic logic [4:0] xy_route(input logic [ID_X_W-1:0] dx,
                                            input logic [ID_Y_W-1:0] dy,
                                            input logic [ID_X_W-1:0] x,
                                            input logic [ID_Y_W-1:0] y);
        if (dx > x) return 5'b00100;
        if (dx < x) return 5'b10000;
        if (dy > y) return 5'b00010;
        if (dy < y) return 5'b01000;
        return 5'b00001;
    endfunction

    // Per-VC head decode: which VCs request the switch and which self-drain.
    always_comb begin
        for (int v = 0; v < CHANNELS; v++) begin
            head[v]     = mem_q[v][rd_ptr_q[v][AW-1:0]];
            empty[v]    = (wr_ptr_q[v] == rd_ptr_q[v]);
            full[v]     = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                          (wr_ptr_q[v][PW-1] != rd_ptr_q[v][PW-1]);
            is_head[v]  = head[v][FLIT_W-2];
            is_tail[v]  = head[v][FLIT_W-1];
            route[v]    = xy_route(head[v][ID_X_W-1:0], head[v][ID_X_W+ID_Y_W-1:ID_X_W],
                                   id_x, id_y);
            req[v]      = 1'b0;
            drop_pop[v] = 1'b0;
            req_port[v] = lock_q[v];
            if (!empty[v]) begin
                unique case (state_q[v])
                    StIdle: begin
                        if (is_head[v] && |(route[v] & ACTIVATE_PORT)) begin
                            req[v]      = 1'b1;
                            req_port[v] = route[v];
                        end else begin
                            drop_pop[v] = 1'b1;
                        end
                    end
                    StRoute: req[v]      = 1'b1;
                    StDrop:  drop_pop[v] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_vc    = rr_q;
        cand_vc   = '0;
        idx       = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx     = (int'(rr_q) + i) % CHANNELS;
            cand_vc = VC_W'(idx);
            if (!arb_found && req[cand_vc]) begin
                arb_found = 1'b1;
                arb_vc    = cand_vc;
            end
        end
    end

    // A stalled request keeps its VC so the switch sees a stable flit.
    assign sel_vc             = hold_q ? hold_vc_q : arb_vc;
    assign link.out_valid     = hold_q | arb_found;
    assign hs                 = link.out_valid & link.out_ready;
    assign link.out_flit      = link.out_valid ? head[sel_vc] : '0;
    assign link.out_port      = link.out_valid ? req_port[sel_vc] : '0;
    assign link.out_vc        = link.out_valid ? sel_vc : '0;
    assign link.credit_valid  = credit_q;
    assign overflow_err       = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        drop_done  = '0;
        rr_d       = rr_q;
        for (int v = 0; v < CHANNELS; v++) begin
            pop[v]      = drop_pop[v] | (hs && (sel_vc == VC_W'(v)));
            wr_en[v]    = link.in_valid && (link.in_vc == VC_W'(v));
            push[v]     = wr_en[v] && (!full[v] || pop[v]);
            if (wr_en[v] && full[v] && !pop[v]) overflow_d = 1'b1;
            wr_ptr_d[v] = wr_ptr_q[v] + PW'(push[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop[v]);
            state_d[v]  = state_q[v];
            lock_d[v]   = lock_q[v];
            if (!empty[v]) begin
                unique case (state_q[v])
                    StIdle: begin
                        if (is_head[v]) begin
                            if (req[v]) begin
                                // Head+tail locks and releases within one departure.
                                if (pop[v] && !is_tail[v]) begin
                                    state_d[v] = StRoute;
                                    lock_d[v]  = route[v];
                                end
                            end else if (is_tail[v]) begin
                                drop_done[v] = 1'b1;
                            end else begin
                                state_d[v] = StDrop;
                            end
                        end
                    end
                    StRoute: if (pop[v] && is_tail[v]) state_d[v] = StIdle;
                    StDrop: begin
                        if (is_tail[v]) begin
                            state_d[v]   = StIdle;
                            drop_done[v] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (hs) rr_d = (sel_vc == VC_W'(CHANNELS - 1)) ? '0 : sel_vc + VC_W'(1);
    end

    always_ff @(posedge noc_clk) begin
        for (int v = 0; v < CHANNELS; v++) begin
            if (push[v]) mem_q[v][wr_ptr_q[v][AW-1:0]] <= link.in_flit;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int v = 0; v < CHANNELS; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                state_q[v]  <= StIdle;
                lock_q[v]   <= '0;
            end
            credit_q   <= '0;
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_vc_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                state_q[v]  <= state_d[v];
                lock_q[v]   <= lock_d[v];
            end
            credit_q   <= pop;
            rr_q       <= rr_d;
            hold_q     <= link.out_valid & ~link.out_ready;
            hold_vc_q  <= sel_vc;
            overflow_q <= overflow_d;
        end
    end

`ifdef NOC_INPUT_PORT_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int v = 0; v < CHANNELS; v++) begin
            if (drop_done[v] && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) drop_cnt_q <= '0;
        else            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop_done;
    assign unused_drop_done = ^drop_done;
    assign drop_cnt         = 16'h0;
`endif
endmodule

// File: tb/tb_noc_input_port_vc.sv
// Directed bench for noc_input_port_vc: dut1 has all ports active, dut2 has east disabled.
module tb_noc_input_port_vc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  id_x = 4'd2;
    logic [3:0]  id_y = 4'd2;
    logic        ovf1, ovf2;
    logic [15:0] dc1, dc2;
    int          checks = 0;
    int          errors = 0;

    localparam logic [1:0] HEAD = 2'b01, BODY = 2'b00, TAIL = 2'b10, HT = 2'b11;
`ifdef NOC_INPUT_PORT_STATS_EN
    localparam logic [15:0] DROP_INC = 16'd1;
`else
    localparam logic [15:0] DROP_INC = 16'd0;
`endif

    noc_input_port_vc_if #(.CHANNELS(4), .FLIT_W(32)) if1 ();
    noc_input_port_vc_if #(.CHANNELS(4), .FLIT_W(32)) if2 ();

    noc_input_port_vc #(
        .CHANNELS(4), .DEPTH(4), .FLIT_W(32), .ID_X_W(4), .ID_Y_W(4),
        .ACTIVATE_PORT(5'b11111)
    ) dut1 (
        .noc_clk(clk), .noc_rst_n(rst_n), .id_x(id_x), .id_y(id_y),
        .link(if1.slave), .overflow_err(ovf1), .drop_cnt(dc1)
    );

    noc_input_port_vc #(
        .CHANNELS(4), .DEPTH(4), .FLIT_W(32), .ID_X_W(4), .ID_Y_W(4),
        .ACTIVATE_PORT(5'b11011)
    ) dut2 (
        .noc_clk(clk), .noc_rst_n(rst_n), .id_x(id_x), .id_y(id_y),
        .link(if2.slave), .overflow_err(ovf2), .drop_cnt(dc2)
    );

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [21:0] pl);
        return {t, pl, y, x};
    endfunction

    task automatic drive(input bit d2, input bit v, input logic [1:0] vc, input logic [31:0] f);
        if (d2) begin
            if2.in_valid = v; if2.in_vc = vc; if2.in_flit = f;
        end else begin
            if1.in_valid = v; if1.in_vc = vc; if1.in_flit = f;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid, ovf1, dc1}
            !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got v=%b vc=%0d port=%b flit=%h cr=%b ovf=%b drop=%0d want 0",
                     if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid,
                     ovf1, dc1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({if2.out_valid, if2.out_vc, if2.out_port, if2.out_flit, if2.credit_valid, ovf2, dc2}
            !== '0) begin
            errors++;
            $display("FAIL reset_dut2_after_release: got v=%b port=%b cr=%b ovf=%b drop=%0d want 0",
                     if2.out_valid, if2.out_port, if2.credit_valid, ovf2, dc2);
        end
    endtask

    task automatic test_route_east;
        logic [31:0] f [3];
        f[0] = mk(HEAD, 4'd4, 4'd2, 22'h11);
        f[1] = mk(BODY, 4'd0, 4'd0, 22'h12);
        f[2] = mk(TAIL, 4'd0, 4'd0, 22'h13);
        do_reset();
        if1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'd1, f[i]);
            tick();
            drive(1'b0, 1'b0, 2'd0, 32'h0);
            @(negedge clk);
            checks++;
            if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit} !==
                {1'b1, 2'd1, 5'b00100, f[i]}) begin
                errors++;
                $display("FAIL east_flit%0d: got v=%b vc=%0d port=%b flit=%h want 1 1 00100 %h",
                         i, if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, f[i]);
            end
            checks++;
            if (if1.credit_valid !== ((i == 0) ? 4'b0000 : 4'b0010)) begin
                errors++;
                $display("FAIL east_credit%0d: got %b want %b", i, if1.credit_valid,
                         (i == 0) ? 4'b0000 : 4'b0010);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if1.out_valid, if1.credit_valid} !== {1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL east_last_credit: got v=%b cr=%b want 0 0010",
                     if1.out_valid, if1.credit_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if1.credit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL east_credit_idle: got %b want 0000", if1.credit_valid);
        end
    endtask

    task automatic test_alternate;
        logic [31:0] f [6];
        logic [1:0]  vc [6];
        logic [4:0]  port [6];
        f[0] = mk(HEAD, 4'd2, 4'd2, 22'hA1); vc[0] = 2'd0; port[0] = 5'b00001;
        f[1] = mk(HEAD, 4'd2, 4'd0, 22'hB1); vc[1] = 2'd2; port[1] = 5'b01000;
        f[2] = mk(BODY, 4'd0, 4'd0, 22'hA2); vc[2] = 2'd0; port[2] = 5'b00001;
        f[3] = mk(BODY, 4'd9, 4'd9, 22'hB2); vc[3] = 2'd2; port[3] = 5'b01000;
        f[4] = mk(TAIL, 4'd0, 4'd0, 22'hA3); vc[4] = 2'd0; port[4] = 5'b00001;
        f[5] = mk(TAIL, 4'd9, 4'd9, 22'hB3); vc[5] = 2'd2; port[5] = 5'b01000;
        do_reset();
        if1.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, vc[i], f[i]);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        if1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit} !==
                {1'b1, vc[i], port[i], f[i]}) begin
                errors++;
                $display("FAIL alt_grant%0d: got v=%b vc=%0d port=%b flit=%h want 1 %0d %b %h",
                         i, if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit,
                         vc[i], port[i], f[i]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (if1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_drained: got out_valid=%b want 0", if1.out_valid);
        end
    endtask

    task automatic test_freeze;
        logic [31:0] f0, f3;
        f0 = mk(HT, 4'd2, 4'd2, 22'hC0);
        f3 = mk(HT, 4'd2, 4'd0, 22'hC3);
        do_reset();
        // Move the round-robin pointer to VC3 so an unfrozen arbiter would switch.
        if1.out_ready = 1'b1;
        drive(1'b0, 1'b1, 2'd2, mk(HT, 4'd2, 4'd2, 22'hC2));
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        tick();
        if1.out_ready = 1'b0;
        drive(1'b0, 1'b1, 2'd0, f0);
        tick();
        drive(1'b0, 1'b1, 2'd3, f3);
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit} !==
                {1'b1, 2'd0, 5'b00001, f0}) begin
                errors++;
                $display("FAIL freeze_hold%0d: got v=%b vc=%0d port=%b flit=%h want 1 0 00001 %h",
                         i, if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, f0);
            end
            tick();
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({if1.out_valid, if1.out_vc, if1.out_flit} !== {1'b1, 2'd0, f0}) begin
            errors++;
            $display("FAIL freeze_release_vc0: got v=%b vc=%0d flit=%h want 1 0 %h",
                     if1.out_valid, if1.out_vc, if1.out_flit, f0);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit} !==
            {1'b1, 2'd3, 5'b01000, f3}) begin
            errors++;
            $display("FAIL freeze_then_vc3: got v=%b vc=%0d port=%b flit=%h want 1 3 01000 %h",
                     if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, f3);
        end
        tick();
    endtask

    task automatic test_drop;
        logic [31:0] f [3];
        int valid_seen, credits;
        logic [31:0] fn;
        f[0] = mk(HEAD, 4'd4, 4'd2, 22'hD1);
        f[1] = mk(BODY, 4'd0, 4'd0, 22'hD2);
        f[2] = mk(TAIL, 4'd0, 4'd0, 22'hD3);
        do_reset();
        if2.out_ready = 1'b1;
        valid_seen = 0;
        credits    = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(1'b1, 1'b1, 2'd1, f[i]);
            else       drive(1'b1, 1'b0, 2'd0, 32'h0);
            tick();
            @(negedge clk);
            if (if2.out_valid) valid_seen++;
            credits += int'(if2.credit_valid[1]) + int'(if2.credit_valid[0]) +
                       int'(if2.credit_valid[2]) + int'(if2.credit_valid[3]);
        end
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("FAIL drop_no_valid: got %0d valid cycles want 0", valid_seen);
        end
        checks++;
        if (credits != 3) begin
            errors++;
            $display("FAIL drop_credits: got %0d want 3", credits);
        end
        checks++;
        if (dc2 !== DROP_INC) begin
            errors++;
            $display("FAIL drop_cnt_packet: got %0d want %0d", dc2, DROP_INC);
        end
        // Stray body at an idle VC: drained with a credit but not counted.
        credits = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 2'd0, mk(BODY, 4'd1, 4'd1, 22'hE0));
            else        drive(1'b1, 1'b0, 2'd0, 32'h0);
            tick();
            @(negedge clk);
            if (if2.out_valid) valid_seen++;
            credits += int'(if2.credit_valid[0]);
        end
        checks++;
        if ({valid_seen, credits} != {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL drop_stray_body: got valid=%0d credits=%0d want 0 1", valid_seen, credits);
        end
        checks++;
        if (dc2 !== DROP_INC) begin
            errors++;
            $display("FAIL drop_cnt_stray: got %0d want %0d", dc2, DROP_INC);
        end
        // Single-flit packet to a disabled port counts; north stays routable.
        drive(1'b1, 1'b1, 2'd2, mk(HT, 4'd5, 4'd2, 22'hE1));
        tick();
        fn = mk(HT, 4'd2, 4'd3, 22'hE2);
        drive(1'b1, 1'b1, 2'd3, fn);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        checks++;
        if ({if2.out_valid, if2.out_vc, if2.out_port, if2.out_flit} !==
            {1'b1, 2'd3, 5'b00010, fn}) begin
            errors++;
            $display("FAIL drop_north_ok: got v=%b vc=%0d port=%b flit=%h want 1 3 00010 %h",
                     if2.out_valid, if2.out_vc, if2.out_port, if2.out_flit, fn);
        end
        checks++;
        if (dc2 !== 16'(2 * DROP_INC)) begin
            errors++;
            $display("FAIL drop_cnt_single: got %0d want %0d", dc2, 2 * DROP_INC);
        end
        tick();
    endtask

    task automatic test_overflow;
        logic [31:0] f [5];
        int n;
        f[0] = mk(HEAD, 4'd4, 4'd2, 22'hF0);
        f[1] = mk(BODY, 4'd0, 4'd0, 22'hF1);
        f[2] = mk(BODY, 4'd0, 4'd0, 22'hF2);
        f[3] = mk(BODY, 4'd0, 4'd0, 22'hF3);
        f[4] = mk(TAIL, 4'd0, 4'd0, 22'hF4);
        do_reset();
        if1.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'd2, f[i]);
            tick();
            if (i == 3) begin
                checks++;
                if (ovf1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_full: got %b want 0", ovf1);
                end
            end
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b want 1", ovf1);
        end
        if1.out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if1.out_valid) begin
                if (n < 4) begin
                    checks++;
                    if (if1.out_flit !== f[n]) begin
                        errors++;
                        $display("FAIL ovf_exit%0d: got %h want %h", n, if1.out_flit, f[n]);
                    end
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL ovf_exit_count: got %0d want 4", n);
        end
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", ovf1);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] fn;
        do_reset();
        if1.out_ready = 1'b0;
        drive(1'b0, 1'b1, 2'd1, mk(HEAD, 4'd4, 4'd2, 22'h51));
        tick();
        drive(1'b0, 1'b1, 2'd1, mk(BODY, 4'd0, 4'd0, 22'h52));
        if1.out_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        checks++;
        if (if1.credit_valid !== 4'b0010) begin
            errors++;
            $display("FAIL mid_pre_credit: got %b want 0010", if1.credit_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid, ovf1, dc1}
            !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b vc=%0d port=%b flit=%h cr=%b want 0",
                     if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fn = mk(HT, 4'd2, 4'd0, 22'h53);
        drive(1'b0, 1'b1, 2'd1, fn);
        tick();
        drive(1'b0, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        checks++;
        if ({if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid} !==
            {1'b1, 2'd1, 5'b01000, fn, 4'b0000}) begin
            errors++;
            $display("FAIL mid_new_head: got v=%b vc=%0d port=%b flit=%h cr=%b want 1 1 01000 %h 0",
                     if1.out_valid, if1.out_vc, if1.out_port, if1.out_flit, if1.credit_valid, fn);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if1.credit_valid !== 4'b0010) begin
            errors++;
            $display("FAIL mid_new_credit: got %b want 0010", if1.credit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_route_east();
        test_alternate();
        test_freeze();
        test_drop();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
